// File: rtl/dag_path_counter.sv
// dag_path_counter: stores a topologically-sorted node stream, walks it and accumulates start->end path counts.
// Optional build macro DAG_PATH_SATURATE_EN: count accumulation saturates at all-ones instead of wrapping.
module dag_path_counter #(
    parameter int MAX_NODES    = 1024,
    parameter int NODE_WIDTH   = $clog2(MAX_NODES),
    parameter int RESULT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NODE_WIDTH-1:0]   start_node_idx,
    input  logic [NODE_WIDTH-1:0]   end_node_idx,
    input  logic                    start_end_nodes_valid,
    input  logic                    trimed_done,
    input  logic                    trimed_valid,
    input  logic [NODE_WIDTH-1:0]   trimed_node,
    input  logic                    query_ready,
    output logic                    query_valid,
    output logic [NODE_WIDTH-1:0]   query_data,
    output logic                    reply_ready,
    input  logic                    reply_valid,
    input  logic                    reply_last,
    input  logic [NODE_WIDTH-1:0]   reply_data,
    input  logic                    reply_no_edges_found,
    output logic                    path_count_valid,
    output logic [RESULT_WIDTH-1:0] path_count_value
);
    typedef enum logic [3:0] {LOAD, WAIT_SE, FETCH, READ_U, CHECK, QUERY, REPLY, RMW_RD, RMW_WR, FINISH} state_t;
    state_t state, state_nx;
    logic [NODE_WIDTH-1:0]   order_mem [MAX_NODES];
    logic [RESULT_WIDTH-1:0] count_mem [MAX_NODES];
    logic [NODE_WIDTH-1:0]   wr_ptr, rd_ptr, len, u, v, order_q, cnt_waddr, cnt_raddr;
    logic [RESULT_WIDTH-1:0] cur, count_q, result, sum, cnt_wdata;
    logic                    last, load_we, cnt_we, beat;
    // Last list slot is never filled, so wr_ptr saturates and surplus nodes are dropped.
    assign load_we   = state == LOAD && trimed_valid && wr_ptr != NODE_WIDTH'(MAX_NODES - 1);
    assign beat      = reply_valid && reply_ready;
    assign cnt_we    = load_we || state == RMW_WR;
    assign cnt_waddr = state == RMW_WR ? v : trimed_node;
    assign cnt_wdata = state == RMW_WR ? sum : RESULT_WIDTH'(trimed_node == start_node_idx);
    assign cnt_raddr = state == READ_U ? order_q : v;
`ifdef DAG_PATH_SATURATE_EN
    logic [RESULT_WIDTH:0] wide_sum;
    assign wide_sum = {1'b0, count_q} + {1'b0, cur};
    assign sum      = wide_sum[RESULT_WIDTH] ? '1 : wide_sum[RESULT_WIDTH-1:0];
`else
    assign sum = count_q + cur;
`endif
    assign query_valid      = state == QUERY;
    assign query_data       = u;
    assign reply_ready      = state == REPLY;
    assign path_count_valid = state == FINISH;
    assign path_count_value = result;
    // Order and count memories, both with a registered one-cycle read.
    always_ff @(posedge clk) begin
        if (load_we) order_mem[wr_ptr] <= trimed_node;
        order_q <= order_mem[rd_ptr];
        if (cnt_we) count_mem[cnt_waddr] <= cnt_wdata;
        count_q <= count_mem[cnt_raddr];
    end
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else state <= state_nx;
    end
    // Next-state logic for the load / walk / query sequence.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = trimed_done ? WAIT_SE : LOAD;
            WAIT_SE: state_nx = start_end_nodes_valid ? FETCH : WAIT_SE;
            FETCH:   state_nx = rd_ptr == len ? FINISH : READ_U;
            READ_U:  state_nx = CHECK;
            CHECK:   state_nx = u == end_node_idx ? FINISH : count_q == '0 ? FETCH : QUERY;
            QUERY:   state_nx = query_ready ? REPLY : QUERY;
            REPLY:   state_nx = !beat ? REPLY : !reply_no_edges_found ? RMW_RD : reply_last ? FETCH : REPLY;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = last ? FETCH : REPLY;
            FINISH:  state_nx = FINISH;
            default: state_nx = LOAD;
        endcase
    end
    // Walk pointers, visited node, its count, pending destination and the final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            u      <= '0;
            v      <= '0;
            cur    <= '0;
            last   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_we) wr_ptr <= wr_ptr + NODE_WIDTH'(1);
                    if (trimed_done) len <= wr_ptr + NODE_WIDTH'(load_we);
                end
                WAIT_SE: rd_ptr <= '0;
                FETCH:   if (rd_ptr == len) result <= '0;
                READ_U:  u <= order_q;
                CHECK: begin
                    cur <= count_q;
                    if (u == end_node_idx) result <= count_q;
                    else if (count_q == '0) rd_ptr <= rd_ptr + NODE_WIDTH'(1);
                end
                REPLY: if (beat) begin
                    v    <= reply_data;
                    last <= reply_last;
                    if (reply_no_edges_found && reply_last) rd_ptr <= rd_ptr + NODE_WIDTH'(1);
                end
                RMW_WR:  if (last) rd_ptr <= rd_ptr + NODE_WIDTH'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dag_path_counter.sv
// tb_dag_path_counter: directed DAG walks with an adjacency responder and a result scoreboard.
module tb_dag_path_counter;
    localparam int MN = 32, NW = 5, RW = 4;
    logic clk = 0, rst_n = 0;
    logic [NW-1:0] start_node_idx = '0, end_node_idx = '0, trimed_node = '0, reply_data = '0, query_data;
    logic start_end_nodes_valid = 0, trimed_done = 0, trimed_valid = 0, query_ready = 0;
    logic reply_valid = 0, reply_last = 0, reply_no_edges_found = 0;
    logic query_valid, reply_ready, path_count_valid;
    logic [RW-1:0] path_count_value;
    int tests = 0, failed = 0, qcount = 0, qdelay = 0;
    int adj_n [MN];
    int adj_d [MN][24];
    int node_list[$];
    int exp_q[$];
    bit seen = 0;

    always #5 clk = ~clk;

    dag_path_counter #(.MAX_NODES(MN), .RESULT_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
        .start_end_nodes_valid(start_end_nodes_valid), .trimed_done(trimed_done),
        .trimed_valid(trimed_valid), .trimed_node(trimed_node), .query_ready(query_ready),
        .query_valid(query_valid), .query_data(query_data), .reply_ready(reply_ready),
        .reply_valid(reply_valid), .reply_last(reply_last), .reply_data(reply_data),
        .reply_no_edges_found(reply_no_edges_found), .path_count_valid(path_count_valid),
        .path_count_value(path_count_value)
    );

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_adj();
        foreach (adj_n[i]) adj_n[i] = 0;
    endtask

    task automatic add_edge(int a, int b);
        adj_d[a][adj_n[a]] = b;
        adj_n[a] = adj_n[a] + 1;
    endtask

    task automatic setup_diamond();
        clear_adj();
        add_edge(1, 2); add_edge(1, 3); add_edge(2, 4); add_edge(3, 4);
        node_list = {1, 2, 3, 4};
    endtask

    task automatic do_reset();
        rst_n = 0; trimed_valid = 0; trimed_done = 0; start_end_nodes_valid = 0;
        #1;
        check("reset_outputs", int'({query_valid, query_data, reply_ready, path_count_valid, path_count_value}), 0);
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic load(int s, int e, bit done_with_last);
        start_node_idx = NW'(s);
        end_node_idx   = NW'(e);
        foreach (node_list[i]) begin
            trimed_valid = 1;
            trimed_node  = NW'(node_list[i]);
            trimed_done  = done_with_last && i == node_list.size() - 1;
            tick();
        end
        trimed_valid = 0;
        if (!(done_with_last && node_list.size() > 0)) begin
            trimed_done = 1;
            tick();
        end
        trimed_done = 0;
        tick(); tick();
        start_end_nodes_valid = 1;
    endtask

    task automatic run(string name, int s, int e, bit done_with_last, int exp_val, int exp_queries);
        int g = 0;
        do_reset();
        qcount = 0;
        exp_q.push_back(exp_val);
        load(s, e, done_with_last);
        while (!path_count_valid && g < 3000) begin
            tick();
            g++;
        end
        check({name, "_done"}, int'(path_count_valid), 1);
        if (!path_count_valid) exp_q.delete();
        tick();
        check({name, "_queries"}, qcount, exp_queries);
    endtask

    // Scoreboard monitor: compares each newly presented result with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!path_count_valid) seen = 0;
            else if (!seen) begin
                seen = 1;
                check("sb_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) check("path_count", int'(path_count_value), exp_q.pop_front());
            end
        end
    end

    // Adjacency responder: answers each query from adj_n/adj_d, abandons everything on reset.
    initial begin
        forever begin
            int node, n, g;
            bit ok, xfer;
            tick();
            if (!rst_n || !query_valid) continue;
            node = int'(query_data);
            qcount++;
            ok = 1;
            for (int d = 0; d < qdelay && ok; d++) begin
                tick();
                if (!rst_n) ok = 0;
                else check("query_hold", int'({query_valid, query_data}), int'({1'b1, NW'(node)}));
            end
            if (!ok) continue;
            query_ready = 1;
            tick();
            query_ready = 0;
            n = adj_n[node];
            for (int b = 0; b < (n == 0 ? 1 : n) && rst_n; b++) begin
                reply_valid = 1;
                reply_no_edges_found = (n == 0);
                reply_data = n == 0 ? NW'(0) : NW'(adj_d[node][b]);
                reply_last = b == (n == 0 ? 0 : n - 1);
                g = 0;
                do begin
                    xfer = reply_ready;
                    tick();
                    g++;
                end while (!xfer && rst_n && g < 100);
            end
            reply_valid = 0; reply_last = 0; reply_no_edges_found = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        tick();
        setup_diamond();
        run("diamond", 1, 4, 1, 2, 3);
        trimed_valid = 1; trimed_node = NW'(1);
        tick(); tick();
        trimed_valid = 0; trimed_done = 1;
        tick();
        trimed_done = 0;
        tick();
        check("finish_hold_valid", int'(path_count_valid), 1);
        check("finish_hold_value", int'(path_count_value), 2);

        clear_adj();
        node_list = {5};
        run("single", 5, 5, 0, 1, 0);

        clear_adj();
        add_edge(1, 2); add_edge(1, 6); add_edge(2, 4); add_edge(2, 3);
        node_list = {1, 5, 6, 2, 3};
        qdelay = 4;
        run("chain", 1, 3, 0, 1, 3);
        qdelay = 0;

        clear_adj();
        node_list.delete();
        for (int i = 1; i <= 20; i++) begin
            add_edge(0, i);
            add_edge(i, 21);
        end
        for (int i = 0; i <= 21; i++) node_list.push_back(i);
`ifdef DAG_PATH_SATURATE_EN
        run("parallel", 0, 21, 1, 15, 21);
`else
        run("parallel", 0, 21, 1, 4, 21);
`endif

        clear_adj();
        node_list.delete();
        run("empty", 1, 2, 0, 0, 0);

        setup_diamond();
        do_reset();
        load(1, 4, 0);
        g = 0;
        while (!reply_ready && g < 300) begin
            tick();
            g++;
        end
        check("reached_reply", int'(reply_ready), 1);
        do_reset();
        setup_diamond();
        run("replay", 1, 4, 0, 2, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
